// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    BHOLD  = 2'd2
  } hz_state_t;

  // A taken branch clears IF/ID, ID/EX and EX/MEM; MEM/WB holds the branch itself.
  localparam logic [2:0] FLUSH_BRANCH = 3'b111;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-source forwarding compare/select and load-use detect
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int N  = 24,
  parameter int RW = 4
) (
  input  logic [RW-1:0] src_reg,
  input  logic          src_use,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_reg_write,
  input  logic          mem_is_load,
  input  logic [N-1:0]  mem_result,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_reg_write,
  input  logic [N-1:0]  wb_result,
  output fwd_sel_t      sel,
  output logic [N-1:0]  data,
  output logic          load_hit
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit  = src_use && mem_reg_write && (mem_rd == src_reg);
    wb_hit   = src_use && wb_reg_write && (wb_rd == src_reg);
    load_hit = mem_hit && mem_is_load;
    sel      = FWD_REG;
    data     = '0;
    // A load in MEM has no data yet, so it falls through to WB (or the stall).
    if (mem_hit && !mem_is_load) begin
      sel  = FWD_MEM;
      data = mem_result;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_result;
    end
  end

endmodule

// File: rtl/hazard_ctrl_n.sv
// rtl/hazard_ctrl_n.sv - pipeline hazard, forwarding and flush controller
module hazard_ctrl_n
  import hazard_pkg::*;
#(
  parameter int N       = 24,
  parameter int REGS    = 16,
  parameter int NSRC    = 3,
  parameter int MEM_LAT = 1,
  parameter int NBUF    = 4,
  parameter int CNT_W   = 16,
  localparam int RW     = $clog2(REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0][RW-1:0]   src_reg,
  input  logic [NSRC-1:0]           src_use,
  input  logic [RW-1:0]             mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      mem_is_load,
  input  logic [N-1:0]              mem_result,
  input  logic [RW-1:0]             wb_rd,
  input  logic                      wb_reg_write,
  input  logic [N-1:0]              wb_result,
  input  logic                      branch_taken,
  output logic [NSRC-1:0][1:0]      fwd_sel,
  output logic [NSRC-1:0][N-1:0]    fwd_data,
  output logic                      stall,
  output logic                      bubble,
  output logic [NBUF-1:0]           flush,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  hz_state_t          state, state_next;
  logic [LCW-1:0]     cnt, cnt_next;
  logic [NSRC-1:0]    load_hit;
  logic               load_use;
  logic               flush_ev;
  fwd_sel_t           sel_raw [NSRC];
  logic [N-1:0]       data_raw [NSRC];

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_mux #(.N(N), .RW(RW)) u_fwd_mux (
      .src_reg       (src_reg[i]),
      .src_use       (src_use[i]),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_is_load   (mem_is_load),
      .mem_result    (mem_result),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_result     (wb_result),
      .sel           (sel_raw[i]),
      .data          (data_raw[i]),
      .load_hit      (load_hit[i])
    );
    assign fwd_sel[i]  = rst ? 2'd0 : 2'(sel_raw[i]);
    assign fwd_data[i] = rst ? '0 : data_raw[i];
  end

  assign load_use = |load_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    bubble     = 1'b0;
    flush      = '0;
    flush_ev   = 1'b0;
    if (rst) begin
      flush = '1;
    end else begin
      unique case (state)
        IDLE: begin
          if (branch_taken) begin
            flush      = NBUF'(FLUSH_BRANCH);
            flush_ev   = 1'b1;
            state_next = BHOLD;
          end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (MEM_LAT > 1) begin
              state_next = LSTALL;
              cnt_next   = LCW'(MEM_LAT - 1);
            end
          end
        end
        LSTALL: begin
          if (branch_taken) begin
            flush      = NBUF'(FLUSH_BRANCH);
            flush_ev   = 1'b1;
            cnt_next   = '0;
            state_next = BHOLD;
          end else begin
            stall    = 1'b1;
            bubble   = 1'b1;
            cnt_next = cnt - 1'b1;
            if (cnt == LCW'(1)) state_next = IDLE;
          end
        end
        BHOLD: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_n.sv
// tb/tb_hazard_ctrl_n.sv - self-checking bench for hazard_ctrl_n
module tb_hazard_ctrl_n;

  localparam int N = 24, REGS = 16, RW = 4, NSRC = 3, MEM_LAT = 3, NBUF = 4, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                    clk, rst;
  logic [NSRC-1:0][RW-1:0] src_reg;
  logic [NSRC-1:0]         src_use;
  logic [RW-1:0]           mem_rd, wb_rd;
  logic                    mem_reg_write, mem_is_load, wb_reg_write, branch_taken;
  logic [N-1:0]            mem_result, wb_result;
  logic [NSRC-1:0][1:0]    fwd_sel;
  logic [NSRC-1:0][N-1:0]  fwd_data;
  logic                    stall, bubble;
  logic [NBUF-1:0]         flush;
  logic [CNT_W-1:0]        stall_cnt, flush_cnt;

  hazard_ctrl_n #(.N(N), .REGS(REGS), .NSRC(NSRC), .MEM_LAT(MEM_LAT), .NBUF(NBUF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src_reg(src_reg), .src_use(src_use),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result), .branch_taken(branch_taken),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall(stall), .bubble(bubble), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_reg = '0; src_use = '0; mem_rd = '0; mem_reg_write = 0; mem_is_load = 0;
    mem_result = '0; wb_rd = '0; wb_reg_write = 0; wb_result = '0; branch_taken = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick();
    rst = 0;
  endtask

  task automatic set_load(input logic [3:0] r, input int src);
    src_reg[src] = r; src_use[src] = 1'b1;
    mem_rd = r; mem_reg_write = 1; mem_is_load = 1;
  endtask

  typedef struct {
    logic [2:0][3:0]  sreg;
    logic [2:0]       suse;
    logic [3:0]       mrd;
    logic             mrw;
    logic [23:0]      mres;
    logic [3:0]       wrd;
    logic             wrw;
    logic [23:0]      wres;
    logic [2:0][1:0]  esel;
    logic [2:0][23:0] edata;
  } vec_t;

  vec_t tv [6];

  // behavioural reference for the randomized phase
  int m_rem, m_sc, m_fc;
  bit m_hold;

  initial begin
    logic [2:0][1:0]  es;
    logic [2:0][23:0] ed;
    bit               lu, exp_stall;
    logic [3:0]       exp_flush;

    tv[0] = '{sreg: {4'd0, 4'd0, 4'd3}, suse: 3'b001, mrd: 4'd3, mrw: 1, mres: 24'h00AB12,
              wrd: 4'd0, wrw: 0, wres: 24'h0, esel: {2'd0, 2'd0, 2'd1}, edata: {24'h0, 24'h0, 24'h00AB12}};
    tv[1] = '{sreg: {4'd0, 4'd5, 4'd0}, suse: 3'b010, mrd: 4'd5, mrw: 1, mres: 24'h111111,
              wrd: 4'd5, wrw: 1, wres: 24'h222222, esel: {2'd0, 2'd1, 2'd0}, edata: {24'h0, 24'h111111, 24'h0}};
    tv[2] = '{sreg: {4'd0, 4'd5, 4'd0}, suse: 3'b010, mrd: 4'd5, mrw: 0, mres: 24'h111111,
              wrd: 4'd5, wrw: 1, wres: 24'h222222, esel: {2'd0, 2'd2, 2'd0}, edata: {24'h0, 24'h222222, 24'h0}};
    tv[3] = '{sreg: {4'd0, 4'd0, 4'd0}, suse: 3'b111, mrd: 4'd0, mrw: 1, mres: 24'h0000FF,
              wrd: 4'd0, wrw: 1, wres: 24'h00EE00, esel: {2'd1, 2'd1, 2'd1}, edata: {24'hFF, 24'hFF, 24'hFF}};
    tv[4] = '{sreg: {4'd2, 4'd9, 4'd2}, suse: 3'b101, mrd: 4'd9, mrw: 1, mres: 24'h000AAA,
              wrd: 4'd2, wrw: 1, wres: 24'h000BBB, esel: {2'd2, 2'd0, 2'd2}, edata: {24'hBBB, 24'h0, 24'hBBB}};
    tv[5] = '{sreg: {4'd4, 4'd4, 4'd4}, suse: 3'b111, mrd: 4'd4, mrw: 0, mres: 24'h123456,
              wrd: 4'd4, wrw: 0, wres: 24'h654321, esel: {2'd0, 2'd0, 2'd0}, edata: {24'h0, 24'h0, 24'h0}};

    // reset: matching forwards, a load hazard and a branch are all masked
    clear_inputs();
    rst = 1;
    src_reg[0] = 4'd3; src_use = 3'b111; mem_rd = 4'd3; mem_reg_write = 1; mem_result = 24'h55AA55;
    wb_rd = 4'd0; wb_reg_write = 1; wb_result = 24'h777777; branch_taken = 1;
    #3;
    check("rst flush", 64'(flush), 64'hF);
    check("rst stall", 64'(stall), 64'h0);
    check("rst bubble", 64'(bubble), 64'h0);
    check("rst fwd_sel", 64'(fwd_sel), 64'h0);
    check("rst fwd_data", 64'(fwd_data), 64'h0);
    tick();
    rst = 0; clear_inputs();
    #3;
    check("post-rst stall", 64'(stall), 64'h0);
    check("post-rst stall_cnt", 64'(stall_cnt), 64'h0);
    check("post-rst flush_cnt", 64'(flush_cnt), 64'h0);
    tick();

    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      src_reg = tv[k].sreg; src_use = tv[k].suse; mem_rd = tv[k].mrd; mem_reg_write = tv[k].mrw;
      mem_result = tv[k].mres; wb_rd = tv[k].wrd; wb_reg_write = tv[k].wrw; wb_result = tv[k].wres;
      #3;
      check($sformatf("tv%0d fwd_sel", k), 64'(fwd_sel), 64'(tv[k].esel));
      check($sformatf("tv%0d fwd_data", k), 64'(fwd_data), 64'(tv[k].edata));
      check($sformatf("tv%0d stall", k), 64'(stall), 64'h0);
      tick();
    end

    // load-use lasts exactly MEM_LAT cycles, then WB forwarding
    do_reset();
    set_load(4'd7, 2);
    for (int c = 0; c < MEM_LAT; c++) begin
      #3;
      check($sformatf("lu stall c%0d", c), 64'(stall), 64'h1);
      check($sformatf("lu bubble c%0d", c), 64'(bubble), 64'h1);
      tick();
      mem_reg_write = 0; mem_is_load = 0;
    end
    wb_rd = 4'd7; wb_reg_write = 1; wb_result = 24'h0C0FFE;
    #3;
    check("lu end stall", 64'(stall), 64'h0);
    check("lu stall_cnt", 64'(stall_cnt), 64'd3);
    check("lu wb sel", 64'(fwd_sel[2]), 64'd2);
    check("lu wb data", 64'(fwd_data[2]), 64'h0C0FFE);
    tick();

    // branch in the second stall cycle aborts the stall
    do_reset();
    set_load(4'd7, 2);
    #3; check("br stall c0", 64'(stall), 64'h1);
    tick();
    mem_reg_write = 0; mem_is_load = 0; branch_taken = 1;
    #3;
    check("br flush", 64'(flush), 64'h7);
    check("br stall", 64'(stall), 64'h0);
    tick();
    #3;
    check("bhold flush", 64'(flush), 64'h0);
    check("bhold stall", 64'(stall), 64'h0);
    tick();
    branch_taken = 0;
    #3;
    check("br after stall", 64'(stall), 64'h0);
    check("br flush_cnt", 64'(flush_cnt), 64'd1);
    check("br stall_cnt", 64'(stall_cnt), 64'd1);
    tick();

    // stall counter saturation
    do_reset();
    set_load(4'd9, 0);
    for (int c = 0; c < 20; c++) tick();
    clear_inputs();
    #3; check("sat stall_cnt", 64'(stall_cnt), 64'(CMAX));
    tick();

    // reset in the middle of a stall
    do_reset();
    set_load(4'd7, 1);
    tick();
    clear_inputs(); rst = 1;
    #3;
    check("mid-rst flush", 64'(flush), 64'hF);
    check("mid-rst stall", 64'(stall), 64'h0);
    tick();
    rst = 0;
    #3;
    check("after-rst stall", 64'(stall), 64'h0);
    check("after-rst flush", 64'(flush), 64'h0);
    check("after-rst stall_cnt", 64'(stall_cnt), 64'h0);
    check("after-rst flush_cnt", 64'(flush_cnt), 64'h0);
    tick();
    #3; check("no residual stall", 64'(stall), 64'h0);
    tick();

    // randomized phase against the reference model
    do_reset();
    m_rem = 0; m_sc = 0; m_fc = 0; m_hold = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NSRC; i++) src_reg[i] = 4'($urandom_range(0, 3));
      src_use = 3'($urandom);
      mem_rd = 4'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      mem_is_load = ($urandom_range(0, 2) == 0);
      mem_result = 24'($urandom);
      wb_rd = 4'($urandom_range(0, 3));
      wb_reg_write = 1'($urandom);
      wb_result = 24'($urandom);
      branch_taken = ($urandom_range(0, 9) == 0);
      #3;
      lu = 0;
      for (int i = 0; i < NSRC; i++) begin
        es[i] = 2'd0; ed[i] = '0;
        if (src_use[i] && mem_reg_write && mem_rd == src_reg[i]) begin
          if (mem_is_load) lu = 1;
          else begin es[i] = 2'd1; ed[i] = mem_result; end
        end
        if (es[i] == 2'd0 && src_use[i] && wb_reg_write && wb_rd == src_reg[i]) begin
          es[i] = 2'd2; ed[i] = wb_result;
        end
        if (rst) begin es[i] = 2'd0; ed[i] = '0; end
      end
      exp_stall = 0; exp_flush = 4'h0;
      if (rst) exp_flush = 4'hF;
      else if (m_hold) exp_stall = 0;
      else if (branch_taken) exp_flush = 4'h7;
      else if (m_rem > 0 || lu) exp_stall = 1;
      check($sformatf("rnd%0d fwd_sel", c), 64'(fwd_sel), 64'(es));
      check($sformatf("rnd%0d fwd_data", c), 64'(fwd_data), 64'(ed));
      check($sformatf("rnd%0d stall", c), 64'(stall), 64'(exp_stall));
      check($sformatf("rnd%0d bubble", c), 64'(bubble), 64'(exp_stall));
      check($sformatf("rnd%0d flush", c), 64'(flush), 64'(exp_flush));
      check($sformatf("rnd%0d stall_cnt", c), 64'(stall_cnt), 64'(m_sc));
      check($sformatf("rnd%0d flush_cnt", c), 64'(flush_cnt), 64'(m_fc));
      if (rst) begin
        m_rem = 0; m_sc = 0; m_fc = 0; m_hold = 0;
      end else if (m_hold) begin
        m_hold = 0;
      end else if (branch_taken) begin
        m_hold = 1; m_rem = 0;
        if (m_fc < CMAX) m_fc++;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_sc < CMAX) m_sc++;
      end else if (lu) begin
        m_rem = MEM_LAT - 1;
        if (m_sc < CMAX) m_sc++;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
